// File: rtl/status_clear_arbiter.sv
// Round-robin arbiter for three status-clear requesters feeding a toggle CDC channel.
// Define STATUS_CLR_MERGE_EN to merge all concurrent requests into one transfer.
module status_clear_arbiter #(
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic        SCK,
    input  logic        RST_sync,
    input  logic [2:0]  clr_req,
    input  logic [13:0] clr_mask0,
    input  logic [13:0] clr_mask1,
    input  logic [13:0] clr_mask2,
    input  logic        err_clr,
    input  logic        status_clr_ack_tgl_hf,
    output logic [2:0]  clr_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        status_clr_req_tgl_sck,
    output logic [7:0]  status_clr_lo_sck,
    output logic [5:0]  status_clr_hi_sck
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SEND,
        WAIT_ACK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        ack_meta;
    logic        ack_s;
    logic [7:0]  cnt;
    logic [1:0]  last_winner;
    logic [1:0]  win_q;
    logic [1:0]  win_idx;
    logic [2:0]  win_oh;
    logic [2:0]  grant_set;
    logic [2:0]  grant_q;
    logic [13:0] mask_sel;
    logic [13:0] mask_q;
    logic        match;
    logic        timeout_evt;

    always_ff @(posedge SCK or posedge RST_sync) begin
        if (RST_sync) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= status_clr_ack_tgl_hf;
            ack_s    <= ack_meta;
        end
    end

    // Search order starts at the requester after the previous winner.
    always_comb begin
        win_oh = 3'b000;
        unique case (last_winner)
            2'd0: begin
                if (clr_req[1])      win_oh = 3'b010;
                else if (clr_req[2]) win_oh = 3'b100;
                else if (clr_req[0]) win_oh = 3'b001;
            end
            2'd1: begin
                if (clr_req[2])      win_oh = 3'b100;
                else if (clr_req[0]) win_oh = 3'b001;
                else if (clr_req[1]) win_oh = 3'b010;
            end
            default: begin
                if (clr_req[0])      win_oh = 3'b001;
                else if (clr_req[1]) win_oh = 3'b010;
                else if (clr_req[2]) win_oh = 3'b100;
            end
        endcase
    end

    assign win_idx = win_oh[2] ? 2'd2 : (win_oh[1] ? 2'd1 : 2'd0);

`ifdef STATUS_CLR_MERGE_EN
    assign grant_set = clr_req;
`else
    assign grant_set = win_oh;
`endif

    assign mask_sel = ({14{grant_set[0]}} & clr_mask0)
                    | ({14{grant_set[1]}} & clr_mask1)
                    | ({14{grant_set[2]}} & clr_mask2);

    assign match       = (ack_s == status_clr_req_tgl_sck);
    assign timeout_evt = (state == WAIT_ACK) && !match && (cnt == ACK_TIMEOUT);

    always_ff @(posedge SCK or posedge RST_sync) begin
        if (RST_sync) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (|clr_req) state_n = LATCH;
            LATCH:    state_n = (mask_q != 14'd0) ? SEND : DONE;
            SEND:     state_n = WAIT_ACK;
            WAIT_ACK: if (match) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // The mask is captured at grant so it is stable a cycle before the toggle.
    always_ff @(posedge SCK or posedge RST_sync) begin
        if (RST_sync) begin
            grant_q                <= 3'b000;
            win_q                  <= 2'd0;
            mask_q                 <= 14'd0;
            status_clr_req_tgl_sck <= 1'b0;
            cnt                    <= 8'd0;
            last_winner            <= 2'd2;
            timeout_err            <= 1'b0;
        end else begin
            if (state == IDLE && |clr_req) begin
                grant_q <= grant_set;
                win_q   <= win_idx;
                mask_q  <= mask_sel;
            end
            if (state == LATCH && state_n == SEND)
                status_clr_req_tgl_sck <= ~status_clr_req_tgl_sck;
            if (state == SEND)
                cnt <= 8'd0;
            else if (state == WAIT_ACK && !match && cnt != ACK_TIMEOUT)
                cnt <= cnt + 8'd1;
            if (state == DONE)
                last_winner <= win_q;
            if (timeout_evt)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

    assign status_clr_lo_sck = mask_q[7:0];
    assign status_clr_hi_sck = mask_q[13:8];
    assign clr_done          = (state == DONE) ? grant_q : 3'b000;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_status_clear_arbiter.sv
// Randomized bench for status_clear_arbiter against a transaction-level model.
// Honours STATUS_CLR_MERGE_EN the same way the design does.
module tb_status_clear_arbiter;

    localparam int T = 8;

    logic        SCK = 1'b0;
    logic        RST_sync;
    logic [2:0]  clr_req;
    logic [13:0] mk [3];
    logic        err_clr;
    logic        ack;
    logic [2:0]  clr_done;
    logic        busy;
    logic        timeout_err;
    logic        tgl;
    logic [7:0]  lo;
    logic [5:0]  hi;

    status_clear_arbiter #(.ACK_TIMEOUT(8'(T))) dut (
        .SCK                    (SCK),
        .RST_sync               (RST_sync),
        .clr_req                (clr_req),
        .clr_mask0              (mk[0]),
        .clr_mask1              (mk[1]),
        .clr_mask2              (mk[2]),
        .err_clr                (err_clr),
        .status_clr_ack_tgl_hf  (ack),
        .clr_done               (clr_done),
        .busy                   (busy),
        .timeout_err            (timeout_err),
        .status_clr_req_tgl_sck (tgl),
        .status_clr_lo_sck      (lo),
        .status_clr_hi_sck      (hi)
    );

    always #5 SCK = ~SCK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction-level model state
    bit          active, pend, zero, tgl_m, err_m;
    int          s, ack_cyc, done_cyc, d;
    int          last_w, cur_w, pend_w;
    logic [2:0]  exp_set, pend_set, granted;
    logic [13:0] last_mask, pend_mask;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        active    = 0;
        pend      = 0;
        zero      = 0;
        tgl_m     = 0;
        err_m     = 0;
        last_w    = 2;
        granted   = 3'b000;
        last_mask = 14'd0;
        ack_cyc   = -1;
        done_cyc  = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, clr_done, 0);
        check({tag, "_tgl"},  tgl, 0);
        check({tag, "_mask"}, {hi, lo}, 0);
        check({tag, "_err"},  timeout_err, 0);
    endtask

    task automatic step();
        logic [2:0] exp_done;
        bit         evt;
        bit         idle_now;
        int         w;
        @(negedge SCK);
        cyc++;
        if (pend) begin
            pend      = 0;
            active    = 1;
            s         = cyc;
            last_mask = pend_mask;
            exp_set   = pend_set;
            cur_w     = pend_w;
            zero      = (pend_mask == 14'd0);
            ack_cyc   = -1;
            done_cyc  = zero ? s + 1 : -1;
            d         = $urandom_range(0, T + 3);
        end
        idle_now = !active;
        if (active && !zero && cyc == s + 1) tgl_m = ~tgl_m;
        exp_done = (active && cyc == done_cyc) ? exp_set : 3'b000;
        evt = active && !zero && (cyc >= s + 2 + T)
              && !(ack_cyc >= 0 && cyc >= ack_cyc + 2);

        check("busy", busy, active);
        check("done", clr_done, exp_done);
        check("tgl", tgl, tgl_m);
        check("mask", {hi, lo}, last_mask);
        check("err", timeout_err, err_m);

        if (active && cyc == done_cyc) begin
            last_w = cur_w;
            active = 0;
            for (int i = 0; i < 3; i++)
                if (exp_set[i]) begin
                    clr_req[i] = 1'b0;
                    granted[i] = 1'b0;
                end
        end else if (active && !zero && ack_cyc < 0 && cyc == s + 1 + d) begin
            ack      = tgl_m;
            ack_cyc  = cyc;
            done_cyc = cyc + 3;
        end

        for (int i = 0; i < 3; i++) begin
            if (granted[i]) begin
                if (clr_req[i] && $urandom_range(0, 7) == 0) clr_req[i] = 1'b0;
            end else if (clr_req[i]) begin
                if ($urandom_range(0, 15) == 0) clr_req[i] = 1'b0;
            end else if (!exp_done[i] && $urandom_range(0, 3) == 0) begin
                clr_req[i] = 1'b1;
                mk[i] = ($urandom_range(0, 5) == 0) ? 14'd0 : 14'($urandom);
            end
        end
        err_clr = ($urandom_range(0, 7) == 0);

        err_m = evt ? 1'b1 : (err_clr ? 1'b0 : err_m);
        if (idle_now && clr_req != 3'b000) begin
            w = last_w;
            for (int k = 3; k >= 1; k--)
                if (clr_req[(last_w + k) % 3]) w = (last_w + k) % 3;
`ifdef STATUS_CLR_MERGE_EN
            pend_set = clr_req;
`else
            pend_set = 3'b001 << w;
`endif
            pend_mask = 14'd0;
            for (int i = 0; i < 3; i++)
                if (pend_set[i]) pend_mask |= mk[i];
            pend_w  = w;
            granted |= pend_set;
            pend    = 1;
        end
    endtask

    task automatic reset_mid_wait();
        int k = 0;
        while (!(active && !zero && cyc > s + 2 && ack_cyc < 0) && k < 400) begin
            step();
            k++;
        end
        check("rst_wait_found", k < 400, 1);
        RST_sync = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        ack     = 1'b0;
        err_clr = 1'b0;
        model_reset();
        @(posedge SCK);
        #1;
        check_reset_outputs("rst_hold");
        #1;
        RST_sync = 1'b0;
    endtask

    initial begin
        RST_sync = 1'b1;
        clr_req  = 3'b000;
        mk[0]    = 14'd0;
        mk[1]    = 14'd0;
        mk[2]    = 14'd0;
        err_clr  = 1'b0;
        ack      = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        #5;
        RST_sync = 1'b0;
        repeat (1500) step();
        reset_mid_wait();
        repeat (1500) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/status_clear_arbiter.md
STATUS_CLEAR_ARBITER -- requirements
Module: status_clear_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255 (8-bit): SCK cycles in WAIT_ACK before timeout_err SHALL set; range 1..255.
REQ-002 SCK  input  1  clock for all logic; requester domain of the status-clear CDC channel.
REQ-003 RST_sync  input  1  asynchronous, active-high reset.
REQ-004 clr_req  input  3  per-requester level request; held until the matching clr_done pulse.
REQ-005 clr_mask0, clr_mask1, clr_mask2  input  14 each  status bits to clear; stable while the matching clr_req is high.
REQ-006 clr_done  output  3  one-cycle completion pulse per requester.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 timeout_err  output  1  sticky: ack not received within ACK_TIMEOUT.
REQ-009 err_clr  input  1  synchronous clear of timeout_err.
REQ-010 status_clr_req_tgl_sck  output  1  request toggle to the CDC channel.
REQ-011 status_clr_lo_sck  output  8  mask bits [7:0] to the CDC channel.
REQ-012 status_clr_hi_sck  output  6  mask bits [13:8] to the CDC channel.
REQ-013 status_clr_ack_tgl_hf  input  1  ack toggle from the HF_CLK domain; asynchronous to SCK.

Function
REQ-014 status_clr_ack_tgl_hf SHALL pass through a 2-flop synchronizer (ack_s) before any use.
REQ-015 States SHALL be IDLE, LATCH, SEND, WAIT_ACK, DONE.
REQ-016 IDLE: if any clr_req is high, grant the round-robin winner, go to LATCH; otherwise stay.
REQ-017 Round-robin: search starts at the requester after last_winner; last_winner resets to 2, so requester 0 wins first after reset.
REQ-018 LATCH: drive the granted mask onto {hi,lo} outputs; if the mask is nonzero go to SEND, else go to DONE with no toggle (zero-mask bypass).
REQ-019 SEND: invert status_clr_req_tgl_sck once; go to WAIT_ACK. The mask is therefore stable at least one cycle before the toggle.
REQ-020 WAIT_ACK: when ack_s equals status_clr_req_tgl_sck, go to DONE; mask outputs and toggle SHALL hold unchanged.
REQ-021 WAIT_ACK timeout: an 8-bit counter cleared on WAIT_ACK entry; at count == ACK_TIMEOUT, set timeout_err and stay in WAIT_ACK (no toggle, no abandon); the counter saturates.
REQ-022 DONE: pulse clr_done for the granted requester(s) for exactly one cycle; update last_winner; go to IDLE.
REQ-023 A requester SHALL drop clr_req the cycle after its clr_done; IDLE samples requests no earlier than the cycle after DONE.
REQ-024 Mask outputs SHALL hold their last value in IDLE.
REQ-025 Latency: nonzero mask, clr_req rising in IDLE at cycle 0, toggle at cycle 2, clr_done 1 cycle after the ack_s match. Zero mask: clr_done at cycle 2.
REQ-026 err_clr and a same-cycle timeout event SHALL resolve to timeout_err = 1 (set wins).
REQ-027 A clr_req that deasserts before grant SHALL be ignored with no done pulse; deassertion after grant SHALL not abort the transaction.

Reset
REQ-028 On RST_sync: state IDLE, clr_done 0, busy 0, timeout_err 0, toggle 0, {hi,lo} 0, ack_s 0, counter 0, last_winner 2.
REQ-029 Reset mid-transaction SHALL abandon it with no clr_done; the system SHALL also reset the HF_CLK side, so toggle and ack realign at 0.

Configuration
REQ-030 With STATUS_CLR_MERGE_EN defined: LATCH ORs the masks of all requesters high in that cycle, and DONE pulses clr_done for each of them; round-robin still updates to the arbitration winner.
REQ-031 Without STATUS_CLR_MERGE_EN: only the winner's mask is sent and only the winner's clr_done pulses.

Verification
REQ-032 Single request: clr_req=001, clr_mask0=14'h0081, ack returned 4 cycles after the toggle -> lo=8'h81, hi=6'h00, one toggle 0->1, clr_done=001 once.
REQ-033 Contention: clr_req=111 held, each requester re-asserting after its done -> grant order 0,1,2,0; exactly one toggle per grant (merge off).
REQ-034 Zero mask: clr_req=010, clr_mask1=0 -> no toggle, clr_done=010 at cycle 2, busy high for 2 cycles.
REQ-035 Timeout: ACK_TIMEOUT=8, ack withheld -> timeout_err=1 after 8 WAIT_ACK cycles, busy stays 1; a late ack then completes normally; err_clr clears timeout_err.
REQ-036 Merge on: clr_req=101, masks 14'h0001 and 14'h2000 -> one toggle carrying mask 14'h2001, clr_done=101 in the same cycle.
REQ-037 Reset in WAIT_ACK: assert RST_sync -> all outputs return to their REQ-028 values at once, no clr_done; the next request completes correctly.
